// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handshake,
// redirect request and status. The master modport is the fetch unit itself.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misalign_err;
    logic [15:0] issued_count;

    modport master (
        output imem_addr, if_valid, if_instr, if_pc, halted, misalign_err, issued_count,
        input  imem_data, if_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, halted, misalign_err, issued_count,
        output imem_data, if_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: walks fetch_pc through a combinational imem, buffers
// {pc, instr} in a 2-entry queue for decode, stops after LAST_PC, and flushes on redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] LAST_PC  = 32'd84
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {FETCH, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    entry_t      q0, q1;
    logic [1:0]  cnt;
    logic        misalign_q;
    logic [15:0] issued_q;

    logic   pop, push;
    entry_t new_entry;

    assign pop       = (cnt != 2'd0) && bus.if_ready;
    assign new_entry = '{pc: fetch_pc_q, instr: bus.imem_data};

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        if (bus.redirect_valid) begin
            state_d    = FETCH;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (state_q == FETCH) begin
            if (fetch_pc_q > LAST_PC) begin
                state_d = DONE;
            end else if ((cnt != 2'd2) || pop) begin
                push = 1'b1;
                // Last word: park fetch_pc on it so imem_addr stays put while halted
                if (fetch_pc_q == LAST_PC) state_d    = DONE;
                else                       fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            q0         <= '0;
            q1         <= '0;
            cnt        <= 2'd0;
            misalign_q <= 1'b0;
            issued_q   <= 16'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            // A transfer in a redirect cycle was still consumed by decode
            if (pop && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
            if (bus.redirect_valid) begin
                cnt <= 2'd0;
                q0  <= '0;
                q1  <= '0;
                if (bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
            end else begin
                case ({push, pop})
                    2'b01: begin
                        q0  <= q1;
                        cnt <= cnt - 2'd1;
                    end
                    2'b10: begin
                        if (cnt == 2'd0) q0 <= new_entry;
                        else             q1 <= new_entry;
                        cnt <= cnt + 2'd1;
                    end
                    2'b11: begin
                        if (cnt == 2'd1) q0 <= new_entry;
                        else begin
                            q0 <= q1;
                            q1 <= new_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_addr    = fetch_pc_q;
    assign bus.if_valid     = (cnt != 2'd0);
    assign bus.if_pc        = q0.pc;
    assign bus.if_instr     = q0.instr;
    assign bus.halted       = (state_q == DONE) && (cnt == 2'd0);
    assign bus.misalign_err = misalign_q;
    assign bus.issued_count = issued_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small imem model and
// hand-computed expectations for sequencing, stalls, redirects and halt.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(32'd0), .LAST_PC(32'd84)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:31];
    assign bus.imem_data = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        if (pc == 32'd0)      return 32'h0000_83B3;
        else if (pc == 32'd4) return 32'h0005_00B3;
        else                  return 32'hA000_0000 + pc;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] epc;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
        mem[0] = 32'h0000_83B3;
        mem[1] = 32'h0005_00B3;

        // Reset must win over a concurrent redirect and a ready decode stage
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd6;
        do_reset();
        chk("rst_valid",    32'(bus.if_valid), 32'd0);
        chk("rst_pc",       bus.if_pc, 32'd0);
        chk("rst_instr",    bus.if_instr, 32'd0);
        chk("rst_halted",   32'(bus.halted), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        chk("rst_issued",   32'(bus.issued_count), 32'd0);
        chk("rst_addr",     bus.imem_addr, 32'd0);

        // First instructions stream through at one per cycle
        step();
        chk("a_valid", 32'(bus.if_valid), 32'd1);
        chk("a_pc0",   bus.if_pc, 32'd0);
        chk("a_ins0",  bus.if_instr, 32'h0000_83B3);
        step();
        chk("a_pc4",   bus.if_pc, 32'd4);
        chk("a_ins4",  bus.if_instr, 32'h0005_00B3);
        step();
        chk("a_pc8",   bus.if_pc, 32'd8);
        chk("a_ins8",  bus.if_instr, 32'hA000_0008);
        chk("a_issued", 32'(bus.issued_count), 32'd2);

        // Stall: queue fills with pc 0,4 and fetch_pc parks at 8
        bus.if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("b_valid", 32'(bus.if_valid), 32'd1);
        chk("b_pc0",   bus.if_pc, 32'd0);
        chk("b_addr",  bus.imem_addr, 32'd8);
        bus.if_ready = 1'b1;
        step();
        chk("b_pc4",   bus.if_pc, 32'd4);
        step();
        chk("b_pc8",   bus.if_pc, 32'd8);
        chk("b_issued", 32'(bus.issued_count), 32'd2);

        // Redirect to 56 with a full queue
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd56;
        step();
        bus.redirect_valid = 1'b0;
        chk("c_valid", 32'(bus.if_valid), 32'd0);
        chk("c_addr",  bus.imem_addr, 32'd56);
        step();
        chk("c_valid2", 32'(bus.if_valid), 32'd1);
        chk("c_pc56",   bus.if_pc, 32'd56);
        chk("c_ins56",  bus.if_instr, 32'hA000_0038);
        chk("c_issued", 32'(bus.issued_count), 32'd2);
        chk("c_misal",  32'(bus.misalign_err), 32'd0);

        // Transfer coinciding with a redirect: counted, then flushed
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        step();
        bus.redirect_valid = 1'b0;
        chk("d_issued", 32'(bus.issued_count), 32'd3);
        chk("d_valid",  32'(bus.if_valid), 32'd0);
        chk("d_addr",   bus.imem_addr, 32'd40);

        // Full run to LAST_PC then halt
        do_reset();
        n   = 0;
        epc = 32'd0;
        for (int c = 0; c < 40 && !bus.halted; c++) begin
            step();
            if (bus.if_valid && !bus.halted) begin
                chk("e_pc",    bus.if_pc, epc);
                chk("e_instr", bus.if_instr, exp_instr(epc));
                epc += 32'd4;
                n++;
            end
        end
        chk("e_halt_seen", 32'(bus.halted), 32'd1);
        chk("e_xfers",     32'(n), 32'd22);
        for (int i = 0; i < 3; i++) step();
        chk("e_halted", 32'(bus.halted), 32'd1);
        chk("e_issued", 32'(bus.issued_count), 32'd22);
        chk("e_addr",   bus.imem_addr, 32'd84);
        chk("e_valid",  32'(bus.if_valid), 32'd0);

        // Misaligned redirect out of DONE
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd6;
        step();
        bus.redirect_valid = 1'b0;
        chk("f_misal",  32'(bus.misalign_err), 32'd1);
        chk("f_addr",   bus.imem_addr, 32'd4);
        chk("f_halted", 32'(bus.halted), 32'd0);
        bus.if_ready = 1'b0;
        step();
        chk("f_pc4",    bus.if_pc, 32'd4);
        chk("f_ins4",   bus.if_instr, 32'h0005_00B3);
        chk("f_sticky", 32'(bus.misalign_err), 32'd1);

        // Redirect past LAST_PC: enter DONE without pushing anything
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd88;
        step();
        bus.redirect_valid = 1'b0;
        chk("g_halted0", 32'(bus.halted), 32'd0);
        step();
        chk("g_halted1", 32'(bus.halted), 32'd1);
        chk("g_valid",   32'(bus.if_valid), 32'd0);
        chk("g_addr",    bus.imem_addr, 32'd88);

        // Reset clears the sticky error
        do_reset();
        chk("h_misal", 32'(bus.misalign_err), 32'd0);
        chk("h_issued", 32'(bus.issued_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: PC loaded on reset.
REQ-002 SHALL have parameter LAST_PC, default 32'd84: highest valid instruction byte address in instruction memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory (word entries at multiples of 4).
REQ-006 SHALL have port imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port if_valid  output  1  head of queue holds a valid instruction.
REQ-008 SHALL have port if_ready  input  1  decode stage accepts the head this cycle.
REQ-009 SHALL have port if_instr  output  32  head instruction word.
REQ-010 SHALL have port if_pc  output  32  byte address of head instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-012 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-013 SHALL have port halted  output  1  fetch finished and queue empty.
REQ-014 SHALL have port misalign_err  output  1  sticky: a redirect target was not 4-byte aligned.
REQ-015 SHALL have port issued_count  output  16  instructions accepted by decode, saturating.

Function
REQ-016 SHALL hold fetch_pc register; imem_addr = fetch_pc combinationally.
REQ-017 SHALL contain a 2-entry FIFO of {pc, instr}; if_valid = FIFO non-empty; if_instr/if_pc = head entry.
REQ-018 SHALL count a transfer when if_valid && if_ready; the transfer pops the head.
REQ-019 SHALL have states FETCH and DONE.
REQ-020 In FETCH with no redirect: push {fetch_pc, imem_data} and fetch_pc += 4 when FIFO not full, or full with a pop the same cycle; otherwise hold fetch_pc.
REQ-021 FETCH -> DONE on the push of an entry whose pc equals LAST_PC; any fetch_pc > LAST_PC in FETCH SHALL also enter DONE without a push.
REQ-022 In DONE: no pushes; fetch_pc held; pops continue.
REQ-023 halted = (state == DONE) && FIFO empty.
REQ-024 redirect_valid SHALL take priority over push and pop: FIFO cleared, fetch_pc <= redirect_pc, no push that cycle, state <= FETCH (from either state).
REQ-025 A transfer coinciding with a redirect SHALL still count in issued_count (decode consumed it); the entry is nevertheless flushed.
REQ-026 A redirect with redirect_pc[1:0] != 0 SHALL set misalign_err, load fetch_pc <= {redirect_pc[31:2], 2'b00}, and otherwise behave per REQ-024.
REQ-027 Latency: instruction at fetch_pc appears at if_valid on the cycle after the push edge; with if_ready held high, throughput is 1 instruction/cycle.
REQ-028 FIFO SHALL never overflow or underflow; full + push without pop is impossible by REQ-020.
REQ-029 issued_count SHALL saturate at 16'hFFFF.

Reset
REQ-030 On reset: fetch_pc = RESET_PC, FIFO empty, state FETCH, if_valid = 0, if_instr = 0, if_pc = 0, halted = 0, misalign_err = 0, issued_count = 0.
REQ-031 Reset SHALL override redirect_valid and any in-flight transfer; no count increments in a reset cycle.

Verification
REQ-032 Reset, if_ready=1, mem[0]=32'h000083B3, mem[4]=32'h000500B3 -> cycle 1: if_valid=1, if_pc=0, if_instr=32'h000083B3; cycle 2: if_pc=4, if_instr=32'h000500B3.
REQ-033 if_ready=0 for 5 cycles after reset -> FIFO holds pc 0 and 4, fetch_pc=8 steady, imem_addr=8; raise if_ready -> pc 0,4,8 in consecutive cycles.
REQ-034 Redirect to 32'd56 while FIFO holds 2 entries -> next cycle if_valid=0, imem_addr=56; the cycle after, if_pc=56.
REQ-035 Run with if_ready=1 from reset, LAST_PC=84 -> 22 transfers (pc 0..84), then halted=1, issued_count=22, imem_addr=84 held.
REQ-036 From halted, redirect to 32'd6 -> misalign_err=1, fetch restarts at pc 4, halted=0.
REQ-037 Transfer and redirect in the same cycle -> issued_count increments by 1, FIFO empty next cycle.
